interrupt_sequencer: RTL and testbench

Executes the 7-cycle 6502 interrupt/reset entry sequence once the instruction loader has injected a forced BRK (opcode 0x00). It pushes PCH, PCL and P to the stack page, or suppresses the pushes on reset. It then fetches the vector from 0xFFFA/0xFFFC/0xFFFE, loads PC and signals the loader that the I flag has been written. It sits between the instruction loader and the address/data bus muxes, on the consuming side of the loader's interrupt handshake.

---
 rtl/interrupt_sequencer_if.sv | 40 ++++
 rtl/interrupt_sequencer.sv | 156 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// Bus and handshake bundle between the instruction loader, the bus muxes
// and the interrupt sequencer. The master drives requests and bus inputs;
// the slave (the sequencer) drives addresses, write data and strobes.
interface interrupt_sequencer_if;
  logic        enableFFs;
  logic        start;
  logic        srcReset;
  logic        srcNmi;
  logic        srcBrk;
  logic        nmiLate;
  logic [15:0] pc;
  logic [7:0]  psr;
  logic [7:0]  sp;
  logic [7:0]  dataIn;

  logic [15:0] addressOut;
  logic [7:0]  dataOut;
  logic        writeEnable;
  logic [7:0]  spNext;
  logic        spWrite;
  logic [15:0] pcNext;
  logic        pcLoad;
  logic        interruptFlagWasSet;
  logic        setIFlag;
  logic        busy;

  modport master (
    output enableFFs, start, srcReset, srcNmi, srcBrk, nmiLate,
           pc, psr, sp, dataIn,
    input  addressOut, dataOut, writeEnable, spNext, spWrite,
           pcNext, pcLoad, interruptFlagWasSet, setIFlag, busy
  );

  modport slave (
    input  enableFFs, start, srcReset, srcNmi, srcBrk, nmiLate,
           pc, psr, sp, dataIn,
    output addressOut, dataOut, writeEnable, spNext, spWrite,
           pcNext, pcLoad, interruptFlagWasSet, setIFlag, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset entry sequencer: dummy read, three stack pushes
// (suppressed for RESET), two vector reads, then a PC load. A late NMI
// during T1-T4 hijacks an IRQ/BRK onto the NMI vector.
module interrupt_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    T1_DUMMY,
    T2_PUSH_PCH,
    T3_PUSH_PCL,
    T4_PUSH_P,
    T5_VEC_LO,
    T6_VEC_HI
  } state_t;

  typedef enum logic [1:0] {
    SRC_IRQ,
    SRC_BRK,
    SRC_NMI,
    SRC_RESET
  } src_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  state_t      state;
  src_t        src;
  logic [15:0] ret_addr;
  logic [7:0]  sp_cur;
  logic [7:0]  vec_lo;
  logic [15:0] vec_base;

  src_t        start_src;
  logic        in_push;
  logic        hijack;
  logic [7:0]  pushed_p;

  // Decode the requesting source with RESET > NMI > BRK > IRQ priority.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, otherwise a missing branch silently infers a latch.
    start_src = SRC_IRQ;
    if (bus.srcReset)    start_src = SRC_RESET;
    else if (bus.srcNmi) start_src = SRC_NMI;
    else if (bus.srcBrk) start_src = SRC_BRK;
  end

  assign in_push = (state == T2_PUSH_PCH) || (state == T3_PUSH_PCL) ||
                   (state == T4_PUSH_P);

  // A late NMI only redirects maskable sources, and only before the vector fetch.
  assign hijack = bus.nmiLate &&
                  ((src == SRC_IRQ) || (src == SRC_BRK)) &&
                  ((state == T1_DUMMY) || in_push);

  // Pushed status: bit 5 always set, B only for a software BRK.
  assign pushed_p = (src == SRC_BRK) ? (bus.psr | 8'h30)
                                     : ((bus.psr | 8'h20) & 8'hEF);

  // Sequence state and per-sequence registers; all advance only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state    <= IDLE;
      src      <= SRC_IRQ;
      ret_addr <= 16'h0000;
      sp_cur   <= 8'h00;
      vec_lo   <= 8'h00;
      vec_base <= 16'h0000;
    end else if (bus.enableFFs) begin
      if (hijack) vec_base <= VEC_NMI;
      case (state)
        IDLE: begin
          if (bus.start) begin
            src      <= start_src;
            ret_addr <= (start_src == SRC_BRK) ? bus.pc + 16'd1 : bus.pc;
            sp_cur   <= bus.sp;
            case (start_src)
              SRC_RESET: vec_base <= VEC_RESET;
              SRC_NMI:   vec_base <= VEC_NMI;
              default:   vec_base <= VEC_IRQ;
            endcase
            state <= T1_DUMMY;
          end
        end
        T1_DUMMY:    state <= T2_PUSH_PCH;
        T2_PUSH_PCH: begin
          sp_cur <= sp_cur - 8'd1;
          state  <= T3_PUSH_PCL;
        end
        T3_PUSH_PCL: begin
          sp_cur <= sp_cur - 8'd1;
          state  <= T4_PUSH_P;
        end
        T4_PUSH_P: begin
          sp_cur <= sp_cur - 8'd1;
          state  <= T5_VEC_LO;
        end
        T5_VEC_LO: begin
          vec_lo <= bus.dataIn;
          state  <= T6_VEC_HI;
        end
        T6_VEC_HI:   state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // Bus outputs decoded from state and registers; strobes gated by the enable.
  always_comb begin
    bus.addressOut          = 16'h0000;
    bus.dataOut             = 8'h00;
    bus.writeEnable         = 1'b0;
    bus.spNext              = 8'h00;
    bus.spWrite             = 1'b0;
    bus.pcNext              = 16'h0000;
    bus.pcLoad              = 1'b0;
    bus.interruptFlagWasSet = 1'b0;
    bus.setIFlag            = 1'b0;
    bus.busy                = (state != IDLE);
    case (state)
      T1_DUMMY: bus.addressOut = bus.pc;
      T2_PUSH_PCH, T3_PUSH_PCL, T4_PUSH_P: begin
        bus.addressOut = {8'h01, sp_cur};
        bus.spNext     = sp_cur - 8'd1;
        bus.spWrite    = bus.enableFFs;
        if (src != SRC_RESET) begin
          bus.writeEnable = bus.enableFFs;
          case (state)
            T2_PUSH_PCH: bus.dataOut = ret_addr[15:8];
            T3_PUSH_PCL: bus.dataOut = ret_addr[7:0];
            default:     bus.dataOut = pushed_p;
          endcase
        end
      end
      T5_VEC_LO: begin
        bus.addressOut          = vec_base;
        bus.setIFlag            = bus.enableFFs;
        bus.interruptFlagWasSet = bus.enableFFs;
      end
      T6_VEC_HI: begin
        bus.addressOut = vec_base + 16'd1;
        bus.pcNext     = {bus.dataIn, vec_lo};
        bus.pcLoad     = bus.enableFFs;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed test-plan scenarios
// plus randomized sequences checked cycle by cycle against a reference model
// that derives each bus cycle from the entry-sequence rules.
module tb_interrupt_sequencer;

  logic clk;
  logic rst;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef enum int {M_IRQ, M_BRK, M_NMI, M_RESET} msrc_t;

  typedef struct packed {
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        we;
    logic [7:0]  spn;
    logic        spw;
    logic [15:0] pcn;
    logic        pcl;
    logic        seti;
    logic        ifws;
  } obs_t;

  // Reference model state for the transaction in flight.
  msrc_t       m_src;
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  logic [7:0]  m_sp;
  logic [7:0]  m_pushed_p;
  logic [15:0] m_base;
  logic [7:0]  m_vlo;

  function automatic obs_t get_obs();
    obs_t o;
    o.busy = bus.busy;
    o.addr = bus.addressOut;
    o.dout = bus.dataOut;
    o.we   = bus.writeEnable;
    o.spn  = bus.spNext;
    o.spw  = bus.spWrite;
    o.pcn  = bus.pcNext;
    o.pcl  = bus.pcLoad;
    o.seti = bus.setIFlag;
    o.ifws = bus.interruptFlagWasSet;
    return o;
  endfunction

  // Expected outputs for step k (0 = idle, 1..6 = T1..T6), enable level and
  // the data bus value currently driven.
  function automatic obs_t exp_out(input int k, input bit en, input logic [7:0] din);
    obs_t        e;
    logic [7:0]  s;
    e = '0;
    e.busy = (k != 0);
    if (k == 1) begin
      e.addr = m_pc;
    end else if (k >= 2 && k <= 4) begin
      s      = m_sp - 8'(k - 2);
      e.addr = {8'h01, s};
      e.spn  = s - 8'd1;
      e.spw  = en;
      if (m_src != M_RESET) begin
        e.we   = en;
        e.dout = (k == 2) ? m_ret[15:8] : (k == 3) ? m_ret[7:0] : m_pushed_p;
      end
    end else if (k == 5) begin
      e.addr = m_base;
      e.seti = en;
      e.ifws = en;
    end else if (k == 6) begin
      e.addr = m_base + 16'd1;
      e.pcn  = {din, m_vlo};
      e.pcl  = en;
    end
    return e;
  endfunction

  // Drives one full sequence from an idle cycle with start through the return
  // to idle. hij: step in which nmiLate is pulsed (0 = never). stall_k/stall_n:
  // enableFFs held low for stall_n cycles at the start of step stall_k.
  task automatic run_seq(input string name, input logic r, input logic n,
                         input logic b, input logic [15:0] pc,
                         input logic [7:0] psr, input logic [7:0] sp,
                         input logic [7:0] vlo, input logic [7:0] vhi,
                         input int hij, input int stall_k, input int stall_n);
    int   ks[$];
    bit   ens[$];
    obs_t e;
    obs_t o;
    m_src = r ? M_RESET : n ? M_NMI : b ? M_BRK : M_IRQ;
    m_pc  = pc;
    m_ret = (m_src == M_BRK) ? pc + 16'd1 : pc;
    m_sp  = sp;
    m_pushed_p = (m_src == M_BRK) ? (psr | 8'h30) : ((psr | 8'h20) & 8'hEF);
    m_base = (m_src == M_RESET) ? 16'hFFFC : (m_src == M_NMI) ? 16'hFFFA : 16'hFFFE;
    if ((m_src == M_IRQ || m_src == M_BRK) && hij >= 1 && hij <= 4) m_base = 16'hFFFA;
    m_vlo = vlo;

    ks.push_back(0); ens.push_back(1'b1);
    for (int k = 1; k <= 6; k++) begin
      if (k == stall_k)
        for (int j = 0; j < stall_n; j++) begin ks.push_back(k); ens.push_back(1'b0); end
      ks.push_back(k); ens.push_back(1'b1);
    end
    ks.push_back(0); ens.push_back(1'b1);

    bus.pc  = pc;
    bus.psr = psr;
    for (int i = 0; i < ks.size(); i++) begin
      bus.enableFFs = ens[i];
      if (i == 0) begin
        bus.start    = 1'b1;
        bus.srcReset = r;
        bus.srcNmi   = n;
        bus.srcBrk   = b;
        bus.sp       = sp;
        bus.nmiLate  = 1'b0;
        bus.dataIn   = 8'($urandom);
      end else begin
        // Inputs that must be ignored while busy are scrambled.
        bus.start    = (i == ks.size() - 1) ? 1'b0 : 1'($urandom);
        bus.srcReset = 1'($urandom);
        bus.srcNmi   = 1'($urandom);
        bus.srcBrk   = 1'($urandom);
        bus.sp       = 8'($urandom);
        bus.dataIn   = 8'($urandom);
        bus.nmiLate  = ens[i] ? (ks[i] == hij) : 1'($urandom);
        if (ens[i] && ks[i] == 5) bus.dataIn = vlo;
        if (ens[i] && ks[i] == 6) bus.dataIn = vhi;
      end
      @(negedge clk);
      e = exp_out(ks[i], ens[i], bus.dataIn);
      o = get_obs();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s cyc=%0d step=%0d en=%0d got busy=%b addr=%h dout=%h we=%b spn=%h spw=%b pcn=%h pcl=%b seti=%b ifws=%b exp busy=%b addr=%h dout=%h we=%b spn=%h spw=%b pcn=%h pcl=%b seti=%b ifws=%b",
                 name, i, ks[i], ens[i], o.busy, o.addr, o.dout, o.we, o.spn, o.spw,
                 o.pcn, o.pcl, o.seti, o.ifws, e.busy, e.addr, e.dout, e.we, e.spn,
                 e.spw, e.pcn, e.pcl, e.seti, e.ifws);
      end
      @(posedge clk);
      #1;
    end
    bus.start     = 1'b0;
    bus.nmiLate   = 1'b0;
    bus.enableFFs = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    #12;
    o = get_obs();
    checks++;
    if (o !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_irq();
    run_seq("irq", 1'b0, 1'b0, 1'b0, 16'h1234, 8'h20, 8'hFD, 8'h00, 8'h80, 0, 0, 0);
  endtask

  task automatic test_brk();
    run_seq("brk_wrap", 1'b0, 1'b0, 1'b1, 16'h12FF, 8'h00, 8'hFD, 8'h34, 8'h12, 0, 0, 0);
    run_seq("brk_pc_ffff", 1'b0, 1'b0, 1'b1, 16'hFFFF, 8'hFF, 8'h80, 8'h00, 8'hC0, 0, 0, 0);
  endtask

  task automatic test_reset_source();
    run_seq("reset_src", 1'b1, 1'b1, 1'b1, 16'hABCD, 8'h5A, 8'h00, 8'h00, 8'hE0, 0, 0, 0);
  endtask

  task automatic test_nmi_hijack();
    run_seq("nmi_hijack", 1'b0, 1'b0, 1'b0, 16'h4000, 8'h04, 8'hF0, 8'h11, 8'h22, 3, 0, 0);
    run_seq("nmi_direct", 1'b0, 1'b1, 1'b1, 16'h0200, 8'hC3, 8'h10, 8'h33, 8'h44, 0, 0, 0);
  endtask

  task automatic test_stall();
    run_seq("stall_t3", 1'b0, 1'b0, 1'b0, 16'h8765, 8'h81, 8'h42, 8'h55, 8'h66, 0, 3, 3);
  endtask

  task automatic test_reset_midseq();
    obs_t o;
    bus.start = 1'b1; bus.srcReset = 1'b0; bus.srcNmi = 1'b0; bus.srcBrk = 1'b0;
    bus.pc = 16'h3000; bus.psr = 8'h00; bus.sp = 8'h80; bus.enableFFs = 1'b1;
    bus.nmiLate = 1'b0; bus.dataIn = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.busy !== 1'b1 || bus.addressOut !== 16'h017E) begin
      failures++;
      $display("FAIL mid_t4 got busy=%b addr=%h exp busy=1 addr=017e", bus.busy, bus.addressOut);
    end
    rst = 1'b1;
    #1;
    o = get_obs();
    checks++;
    if (o !== obs_t'(0)) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_seq("after_reset", 1'b0, 1'b0, 1'b0, 16'h0101, 8'h00, 8'h07, 8'h9A, 8'hBC, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_a", 1'b0, 1'b0, 1'b1, 16'h7FFF, 8'h3C, 8'h01, 8'hAA, 8'hBB, 2, 0, 0);
    run_seq("b2b_b", 1'b0, 1'b1, 1'b0, 16'h0000, 8'hFF, 8'hFF, 8'hCC, 8'hDD, 4, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      run_seq("random", 1'($urandom_range(0, 4) == 0), 1'($urandom),
              1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom), $urandom_range(0, 6),
              $urandom_range(0, 6), $urandom_range(1, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.enableFFs = 1'b1; bus.start = 1'b0; bus.srcReset = 1'b0;
    bus.srcNmi = 1'b0; bus.srcBrk = 1'b0; bus.nmiLate = 1'b0;
    bus.pc = 16'h0000; bus.psr = 8'h00; bus.sp = 8'h00; bus.dataIn = 8'h00;
    test_reset();
    test_irq();
    test_brk();
    test_reset_source();
    test_nmi_hijack();
    test_stall();
    test_reset_midseq();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
